dmem_lsu: RTL

//  Load/store unit between the core datapath and a variable-latency data memory bus.

---
 rtl/dmem_lsu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: word loads/stores over a req/gnt + rvalid bus, stalling the core until done.
// Define DMEM_WBUF_EN to post aligned stores into a single-entry write buffer.
module dmem_lsu #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic          misalign,
  output logic          bus_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
);

  // state  | meaning
  // IDLE   | no bus op; accept next access
  // REQ    | m_req high, bus address/data/we held until m_gnt
  // WAIT   | read granted, waiting for rvalid or timeout
  // DONE   | access complete, core retires the instruction
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access, aligned, timeout, start, stall_fsm;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);
  assign timeout = (cnt == CW'(TIMEOUT));

`ifdef DMEM_WBUF_EN
  // posted: the store in REQ was already retired by the core
  logic posted;
`endif

  always_comb begin
    state_nxt = state;
    stall_fsm = 1'b0;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && aligned) begin
          start     = 1'b1;
          state_nxt = S_REQ;
`ifdef DMEM_WBUF_EN
          stall_fsm = ~memwrite;
`else
          stall_fsm = 1'b1;
`endif
        end
      end
      S_REQ: begin
`ifdef DMEM_WBUF_EN
        stall_fsm = posted ? access : 1'b1;
        if (m_gnt) state_nxt = posted ? S_IDLE : (m_we ? S_DONE : S_WAIT);
`else
        stall_fsm = 1'b1;
        if (m_gnt) state_nxt = m_we ? S_DONE : S_WAIT;
`endif
      end
      S_WAIT: begin
        stall_fsm = 1'b1;
        if (m_rvalid || timeout) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Held reset releases the core even if it keeps presenting the aborted access.
  assign stall = stall_fsm & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      readdata <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
`ifdef DMEM_WBUF_EN
      posted   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      misalign <= (state == S_IDLE) && access && !aligned;
      bus_err  <= (state == S_WAIT) && !m_rvalid && timeout;
      if (state == S_IDLE && access && !aligned) readdata <= '0;
      if (start) begin
        m_addr  <= {addr[AW-1:2], 2'b00};
        m_wdata <= wdata;
        m_we    <= memwrite;
        m_req   <= 1'b1;
`ifdef DMEM_WBUF_EN
        posted  <= memwrite;
`endif
      end
      if (state == S_REQ && m_gnt) begin
        m_req  <= 1'b0;
        cnt    <= '0;
`ifdef DMEM_WBUF_EN
        posted <= 1'b0;
`endif
      end
      if (state == S_WAIT) begin
        if (m_rvalid)     readdata <= m_rdata;
        else if (timeout) readdata <= DW'(32'hDEAD_BEEF);
        else              cnt      <= cnt + CW'(1);
      end
    end
  end

endmodule
